// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl: self-timed stimulus sequencer for the logic unit. It latches one operand
//   pair on start and steps lu_sel through codes 0..NOPS-1. Each code gets SETTLE idle cycles
//   before lu_out is captured into a result buffer and folded into a rotate-XOR signature.
// Latency: final capture NOPS*(SETTLE+1) edges after start acceptance, done pulses the cycle after.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped (no queueing).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op_a, op_b   sweep request and operand pair (latched on acceptance)
//   lu_a, lu_b, lu_sel  registered drive to the logic unit
//   lu_out              combinational result returned by the logic unit
//   busy, done          status: busy outside IDLE, done one-cycle completion pulse
//   rd_addr, rd_data    asynchronous read port of the result buffer
//   signature           running rotate-left-then-XOR signature of captured results
module logic_sweep_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SELW   = 3,
  parameter int NOPS   = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [SELW-1:0]  lu_sel,
  input  logic [WIDTH-1:0] lu_out,
  output logic             busy,
  output logic             done,
  input  logic [SELW-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] signature
);

  // Counter holds values 0..SETTLE; SETTLE+2 keeps the width >= 1 when SETTLE is 0.
  localparam int CW    = $clog2(SETTLE + 2);
  // The buffer covers the whole select space. Entries at codes >= NOPS are never written,
  // so out-of-range reads return their reset value of zero without an address compare.
  localparam int DEPTH = 2 ** SELW;

  localparam logic [SELW-1:0] LAST_SEL = SELW'(NOPS - 1);
  localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    settle_cnt;
  logic [WIDTH-1:0] result_buf [DEPTH];
  logic [WIDTH-1:0] sig_next;

  // Rotate the running signature left by one, then fold in the current result.
  assign sig_next = {signature[WIDTH-2:0], signature[WIDTH-1]} ^ lu_out;

  assign rd_data = result_buf[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lu_a       <= '0;
      lu_b       <= '0;
      lu_sel     <= '0;
      settle_cnt <= '0;
      signature  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        result_buf[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            lu_a       <= op_a;
            lu_b       <= op_b;
            lu_sel     <= '0;
            signature  <= '0;
            settle_cnt <= SETTLE_C;
            busy       <= 1'b1;
            state      <= (SETTLE > 0) ? S_WAIT : S_CAPTURE;
          end
        end

        S_WAIT: begin
          // Leaving on the count==1 edge makes WAIT last exactly SETTLE cycles.
          settle_cnt <= settle_cnt - CW'(1);
          if (settle_cnt == CW'(1)) begin
            state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          result_buf[lu_sel] <= lu_out;
          signature          <= sig_next;
          if (lu_sel == LAST_SEL) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            lu_sel     <= lu_sel + SELW'(1);
            settle_cnt <= SETTLE_C;
            state      <= (SETTLE > 0) ? S_WAIT : S_CAPTURE;
          end
        end

        S_DONE: begin
          // Operands and select hold their last values; start is ignored this cycle.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
